pc_sequencer: RTL and testbench

Registered program-counter unit for the single-issue MIPS-style datapath. Owns the PC register and selects the next PC each cycle from sequential, branch, jump and register-jump sources. Adds features the earlier combinational next-address selector lacked: stall hold, a parametrised return-address stack (RAS) for jal/jr pairs, and sticky error flags. Sits between the control unit/ALU zero flag and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for a single-issue MIPS-style
// datapath. Each cycle it picks the next PC from one of these sources:
// sequential (pc+4), conditional branch, j/jal absolute jump, or jr
// register jump. A jr can instead take its target from a small circular
// return-address stack (RAS) that jal pushes onto. The sticky error flags
// record RAS overflow, RAS underflow and misaligned jr targets.
//
// Parameters
//   PC_WIDTH      PC width in bits (28..32)
//   RESET_VECTOR  PC loaded on reset (bits [1:0] must be 0)
//   RAS_DEPTH     RAS entries (power of 2, 2..16)
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   stall            hold PC, RAS and flags for this cycle
//   jump/jump_link/jump_reg/use_ras, jump_offset   jump controls
//   branch, zero, branch_offset                    conditional branch
//   reg_target       rs value for jr
//   pc               current PC (registered)
//   link_addr        pc+4 (combinational) for the $ra/rd write path
//   ras_empty/ras_full                     RAS occupancy
//   ras_overflow/ras_underflow/misalign    sticky error flags
module pc_sequencer #(
  parameter int          PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                jump,
  input  logic                jump_link,
  input  logic                jump_reg,
  input  logic                use_ras,
  input  logic [25:0]         jump_offset,
  input  logic                branch,
  input  logic                zero,
  input  logic [15:0]         branch_offset,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] link_addr,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_overflow,
  output logic                ras_underflow,
  output logic                misalign
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    top;
  logic [CNT_W-1:0]    count;
  logic                overflow_q;
  logic                underflow_q;
  logic                misalign_q;

  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_disp;
  logic [PC_WIDTH-1:0] reg_aligned;
  logic [PC_WIDTH-1:0] next_pc;
  logic                do_push;
  logic                do_pop;
  logic                set_overflow;
  logic                set_underflow;
  logic                set_misalign;
  logic                advance;
  logic [PTR_W-1:0]    top_inc;
  logic [PTR_W-1:0]    top_dec;

  assign seq         = pc_q + PC_WIDTH'(4);
  assign branch_disp = {{(PC_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign reg_aligned = {reg_target[PC_WIDTH-1:2], 2'b00};
  assign top_inc     = top + PTR_W'(1);
  assign top_dec     = top - PTR_W'(1);

  // A 28-bit PC has no region bits left above the instruction index field,
  // so the jump target is then just the shifted index.
  generate
    if (PC_WIDTH > 28) begin : g_region
      assign jump_target = {seq[PC_WIDTH-1:28], jump_offset, 2'b00};
    end else begin : g_noregion
      assign jump_target = {jump_offset, 2'b00};
    end
  endgenerate

  assign pc            = pc_q;
  assign link_addr     = seq;
  assign ras_empty     = (count == '0);
  assign ras_full      = (count == CNT_W'(RAS_DEPTH));
  assign ras_overflow  = overflow_q;
  assign ras_underflow = underflow_q;
  assign misalign      = misalign_q;

  // Next-PC priority: RAS return, register jump, absolute jump, taken
  // branch, sequential. Jump decoding shadows branch, and jr shadows jal.
  always_comb begin
    next_pc       = seq;
    do_push       = 1'b0;
    do_pop        = 1'b0;
    set_overflow  = 1'b0;
    set_underflow = 1'b0;
    set_misalign  = 1'b0;
    if (jump && jump_reg && use_ras && !ras_empty) begin
      next_pc = ras_mem[top];
      do_pop  = 1'b1;
    end else if (jump && jump_reg) begin
      next_pc       = reg_aligned;
      set_misalign  = (reg_target[1:0] != 2'b00);
      set_underflow = use_ras;
    end else if (jump) begin
      next_pc      = jump_target;
      do_push      = jump_link;
      set_overflow = jump_link && ras_full;
    end else if (branch && zero) begin
      next_pc = seq + branch_disp;
    end
  end

  // While stalled, nothing moves: no PC update, no push or pop, no flag set.
  assign advance = rst_n && !stall;

  // PC, RAS pointer/count and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_VECTOR[PC_WIDTH-1:0];
      top         <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (!stall) begin
      pc_q <= next_pc;
      if (do_push) begin
        // Pushing while full overwrites the oldest entry, so the count
        // saturates while the top pointer keeps advancing around the ring.
        top <= top_inc;
        if (!ras_full) begin
          count <= count + CNT_W'(1);
        end
      end else if (do_pop) begin
        top   <= top_dec;
        count <= count - CNT_W'(1);
      end
      overflow_q  <= overflow_q  | set_overflow;
      underflow_q <= underflow_q | set_underflow;
      misalign_q  <= misalign_q  | set_misalign;
    end
  end

  // RAS storage has no reset; entries are only read once count says valid.
  always_ff @(posedge clk) begin
    if (advance && do_push) begin
      ras_mem[top_inc] <= seq;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. Stimulus is driven on the falling edge and
// the reference model's expected post-edge state is queued; a monitor
// process pops one expectation after each rising edge and compares it.
// The model keeps the RAS as a plain LIFO queue of return addresses.
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'h0000_0400;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic        jump_link;
  logic        jump_reg;
  logic        use_ras;
  logic [25:0] jump_offset;
  logic        branch;
  logic        zero;
  logic [15:0] branch_offset;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misalign;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(RV),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jump         (jump),
    .jump_link    (jump_link),
    .jump_reg     (jump_reg),
    .use_ras      (use_ras),
    .jump_offset  (jump_offset),
    .branch       (branch),
    .zero         (zero),
    .branch_offset(branch_offset),
    .reg_target   (reg_target),
    .pc           (pc),
    .link_addr    (link_addr),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow),
    .misalign     (misalign)
  );

  typedef struct {
    bit        rst_n;
    bit        stall;
    bit        jump;
    bit        jump_link;
    bit        jump_reg;
    bit        use_ras;
    bit [25:0] joff;
    bit        branch;
    bit        zero;
    bit [15:0] boff;
    bit [31:0] rt;
  } ctl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] link;
    logic        empty;
    logic        full;
    logic        of;
    logic        uf;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          compared = 0;
  int          failed   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_of;
  bit          m_uf;
  bit          m_mis;

  function automatic ctl_t idle();
    ctl_t c = '{default: 0};
    c.rst_n = 1'b1;
    return c;
  endfunction

  function automatic ctl_t j_op(input bit [25:0] joff, input bit link);
    ctl_t c = idle();
    c.jump      = 1'b1;
    c.jump_link = link;
    c.joff      = joff;
    return c;
  endfunction

  function automatic ctl_t jr_op(input bit [31:0] rt, input bit ras);
    ctl_t c = idle();
    c.jump     = 1'b1;
    c.jump_reg = 1'b1;
    c.use_ras  = ras;
    c.rt       = rt;
    return c;
  endfunction

  function automatic ctl_t br_op(input bit z, input bit [15:0] boff);
    ctl_t c = idle();
    c.branch = 1'b1;
    c.zero   = z;
    c.boff   = boff;
    return c;
  endfunction

  // Reference model: one rising edge worth of architectural behaviour.
  function automatic void modelStep(input ctl_t c);
    logic [31:0] seq;
    logic [31:0] nxt;
    if (!c.rst_n) begin
      m_pc = RV;
      m_ras.delete();
      m_of  = 1'b0;
      m_uf  = 1'b0;
      m_mis = 1'b0;
      return;
    end
    if (c.stall) return;
    seq = m_pc + 32'd4;
    nxt = seq;
    if (c.jump && c.jump_reg) begin
      if (c.use_ras && m_ras.size() > 0) begin
        nxt = m_ras.pop_back();
      end else begin
        nxt = c.rt & 32'hFFFF_FFFC;
        if (c.rt[1:0] != 2'b00) m_mis = 1'b1;
        if (c.use_ras) m_uf = 1'b1;
      end
    end else if (c.jump) begin
      nxt = (seq & 32'hF000_0000) | (32'(c.joff) * 4);
      if (c.jump_link) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_of = 1'b1;
        end
        m_ras.push_back(seq);
      end
    end else if (c.branch && c.zero) begin
      nxt = seq + 32'(int'($signed(c.boff)) * 4);
    end
    m_pc = nxt;
  endfunction

  task automatic applyStimulus(input ctl_t c);
    exp_t e;
    @(negedge clk);
    rst_n         = c.rst_n;
    stall         = c.stall;
    jump          = c.jump;
    jump_link     = c.jump_link;
    jump_reg      = c.jump_reg;
    use_ras       = c.use_ras;
    jump_offset   = c.joff;
    branch        = c.branch;
    zero          = c.zero;
    branch_offset = c.boff;
    reg_target    = c.rt;
    modelStep(c);
    e.pc    = m_pc;
    e.link  = m_pc + 32'd4;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.of    = m_of;
    e.uf    = m_uf;
    e.mis   = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = {pc, link_addr, ras_empty, ras_full, ras_overflow, ras_underflow, misalign};
    compared++;
    if (a !== e) begin
      failed++;
      $display("[TB] FAIL state #%0d: got pc=%h link=%h eFouM=%b, want pc=%h link=%h eFouM=%b",
               compared, a.pc, a.link, {a.empty, a.full, a.of, a.uf, a.mis},
               e.pc, e.link, {e.empty, e.full, e.of, e.uf, e.mis});
    end
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    ctl_t c;
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; jump_link = 1'b0;
    jump_reg = 1'b0; use_ras = 1'b0; jump_offset = '0; branch = 1'b0;
    zero = 1'b0; branch_offset = '0; reg_target = '0;
    m_pc = RV; m_of = 1'b0; m_uf = 1'b0; m_mis = 1'b0;

    // Reset, then free-running sequential steps.
    c = idle(); c.rst_n = 1'b0;
    applyStimulus(c);
    applyStimulus(c);
    repeat (3) applyStimulus(idle());

    // Branch taken backwards, not taken, and shadowed by a jump.
    applyStimulus(j_op(26'h400, 1'b0));
    applyStimulus(br_op(1'b1, 16'hFFFE));
    applyStimulus(j_op(26'h400, 1'b0));
    applyStimulus(br_op(1'b0, 16'hFFFE));
    applyStimulus(j_op(26'h400, 1'b0));
    c = br_op(1'b1, 16'h0010); c.jump = 1'b1; c.joff = 26'h800;
    applyStimulus(c);

    // jal / jr return pair.
    applyStimulus(j_op(26'h010_0004, 1'b0));
    applyStimulus(j_op(26'h010_0000, 1'b1));
    applyStimulus(jr_op(32'h0, 1'b1));

    // Five jal into a depth-4 RAS, four pops, then an underflowing jr.
    for (int i = 0; i < 5; i++) applyStimulus(j_op(26'h000_1000 + 26'(i * 16), 1'b1));
    for (int i = 0; i < 4; i++) applyStimulus(jr_op(32'h0, 1'b1));
    applyStimulus(jr_op(32'h0000_2003, 1'b1));

    // Stalled jal holds for three cycles and then completes once.
    c = j_op(26'h010_0020, 1'b1); c.stall = 1'b1;
    repeat (3) applyStimulus(c);
    applyStimulus(j_op(26'h010_0020, 1'b1));

    // PC wraparound, then reset during a stalled jal.
    applyStimulus(jr_op(32'hFFFF_FFFC, 1'b0));
    applyStimulus(idle());
    applyStimulus(j_op(26'h000_0100, 1'b1));
    c = j_op(26'h000_0200, 1'b1); c.stall = 1'b1; c.rst_n = 1'b0;
    applyStimulus(c);
    applyStimulus(idle());

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      c           = idle();
      c.rst_n     = ($urandom_range(0, 59) != 0);
      c.stall     = ($urandom_range(0, 4) == 0);
      c.jump      = ($urandom_range(0, 2) == 0);
      c.jump_link = 1'($urandom);
      c.jump_reg  = 1'($urandom);
      c.use_ras   = ($urandom_range(0, 3) != 0);
      c.joff      = 26'($urandom);
      c.branch    = 1'($urandom);
      c.zero      = 1'($urandom);
      c.boff      = 16'($urandom);
      c.rt        = $urandom;
      if ($urandom_range(0, 3) != 0) c.rt[1:0] = 2'b00;
      applyStimulus(c);
    end

    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
